// File: rtl/branch_predictor_btb_pkg.sv
// Shared core definitions: architectural widths, PC increment and the encodings
// used by the branch predictor's direction counters.
package core_pkg;

    localparam int XLEN   = 64;
    localparam int PC_INC = 4;

    function automatic int idx_w(input int entries);
        return $clog2(entries);
    endfunction

    // Weakly taken: MSB set, everything below clear (2'b10 for a 2-bit counter).
    function automatic logic [31:0] ctr_weak_taken(input int ctr_w);
        return 32'(1) << (ctr_w - 1);
    endfunction

    function automatic logic [31:0] ctr_weak_not_taken(input int ctr_w);
        return (32'(1) << (ctr_w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Fetch-lookup / execute-update bus of the branch target buffer.
// upd_valid is a single-cycle strobe with no ready: the BTB always accepts the
// resolved branch presented with it at the next rising edge; all other update
// fields are ignored while upd_valid is low.
interface branch_predictor_btb_if #(
    parameter int ADDR_W = 64,
    parameter int PERF_W = 32
);
    logic [ADDR_W-1:0] lookup_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_mispredict;
    logic              flush;
    logic [PERF_W-1:0] mispredict_count;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush,
        input  pred_hit, pred_taken, pred_target, mispredict_count
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush,
        output pred_hit, pred_taken, pred_target, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating up/down counter with a parallel load; used for the per-entry
// direction counters and the mispredict performance counter.
module sat_counter #(
    parameter int               WIDTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= RST_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && !i_dec && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped, tagged branch target buffer with per-entry saturating direction
// counters, bulk flush and a saturating mispredict counter.
module branch_predictor_btb
    import core_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = XLEN,
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_predictor_btb_if.slave bp
);

    localparam int               IDX_W   = idx_w(ENTRIES);
    localparam int               TAG_W   = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_weak_taken(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_weak_not_taken(CTR_W));

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [CTR_W-1:0]   w_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic             w_train;
    logic             w_alloc;
    logic             w_unused;

    // Byte offset within the instruction word never participates in addressing.
    assign w_unused = ^{bp.lookup_pc[1:0], bp.upd_pc[1:0]};

    assign w_lk_idx = bp.lookup_pc[IDX_W+1:2];
    assign w_lk_tag = bp.lookup_pc[ADDR_W-1:IDX_W+2];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    // Lookup reads stored state only, so a same-index update is seen next cycle.
    assign bp.pred_hit    = w_lk_hit;
    assign bp.pred_taken  = w_lk_hit && w_ctr[w_lk_idx][CTR_W-1];
    assign bp.pred_target = w_lk_hit ? r_target[w_lk_idx] : bp.lookup_pc + ADDR_W'(PC_INC);

    assign w_up_idx = bp.upd_pc[IDX_W+1:2];
    assign w_up_tag = bp.upd_pc[ADDR_W-1:IDX_W+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    // Flush takes priority over training in the same cycle.
    assign w_train = bp.upd_valid && !bp.flush;
    assign w_alloc = w_train && bp.upd_taken && !w_up_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (bp.flush) begin
            r_valid <= '0;
        end else if (w_train && bp.upd_taken) begin
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= bp.upd_target;
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
        logic w_sel;
        assign w_sel = (w_up_idx == IDX_W'(g));

        sat_counter #(
            .WIDTH   (CTR_W),
            .RST_VAL (CTR_WNT)
        ) u_ctr (
            .clk        (clk),
            .reset      (reset),
            .i_load     (w_alloc && w_sel),
            .i_load_val (CTR_WT),
            .i_inc      (w_train && w_up_hit && bp.upd_taken && w_sel),
            .i_dec      (w_train && w_up_hit && !bp.upd_taken && w_sel),
            .o_count    (w_ctr[g])
        );
    end

    // Counts regardless of flush; only reset clears it.
    sat_counter #(
        .WIDTH   (PERF_W),
        .RST_VAL ('0)
    ) u_perf (
        .clk        (clk),
        .reset      (reset),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (bp.upd_valid && bp.upd_mispredict),
        .i_dec      (1'b0),
        .o_count    (bp.mispredict_count)
    );

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised branch target buffer (BTB) with saturating-counter direction prediction.
- Adds next-PC speculation, which the single-cycle core lacks; first block of the pipelined RV64 processor generation.
- Sits beside program_counter in fetch: looked up every cycle with the fetch PC, updated from execute when a branch resolves.
- Direct-mapped, tagged, with synchronous bulk flush and a mispredict performance counter.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, at least 2.
- ADDR_W, 64, PC and target width.
- CTR_W, 2, width of the per-entry saturating direction counter; at least 1.
- PERF_W, 32, width of the mispredict counter.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- lookup_pc  in  ADDR_W  fetch PC.
- pred_hit  out  1  lookup_pc matches a valid entry.
- pred_taken  out  1  pred_hit and counter MSB = 1.
- pred_target  out  ADDR_W  stored target when pred_hit, else lookup_pc+4.
- upd_valid  in  1  resolved-branch update strobe.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual branch outcome.
- upd_target  in  ADDR_W  actual branch target.
- upd_mispredict  in  1  execute detected a misprediction; qualified by upd_valid.
- flush  in  1  invalidate all entries.
- mispredict_count  out  PERF_W  saturating count of mispredicts.

Behaviour:
- Addressing:
  - IDX_W = log2(ENTRIES).
  - index = pc[IDX_W+1:2].
  - tag = pc[ADDR_W-1:IDX_W+2].
  - pc[1:0] is ignored.
- Storage per entry: valid, tag, target (ADDR_W), ctr (CTR_W). Register array, no SRAM macro.
- Lookup is combinational from the stored state: zero latency, same cycle as lookup_pc.
- Lookup miss: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4, wrapping mod 2^ADDR_W.
- Updates take effect at the rising edge when upd_valid=1.
- Update, hit (valid and tag match at the upd_pc index):
  - upd_taken=1: ctr increments, saturating at all-ones; target is overwritten with upd_target.
  - upd_taken=0: ctr decrements, saturating at 0; target is unchanged.
- Update, miss, upd_taken=1: allocate the entry by overwriting the indexed slot. valid=1, tag from upd_pc, target=upd_target, ctr=weakly taken (MSB=1, other bits 0; e.g. 2'b10).
- Update, miss, upd_taken=0: no allocation, no state change.
- mispredict_count increments on each edge where upd_valid and upd_mispredict are both 1. It saturates at all-ones and does not wrap. It is not cleared by flush.
- flush=1 at an edge: all valid bits are cleared; tags, targets and counters are don't-care.
- Simultaneous events:
  - flush and upd_valid in the same cycle: flush wins and no entry is allocated or trained; mispredict_count still counts.
  - lookup_pc and upd_pc mapping to the same index in the same cycle: lookup returns the pre-update contents (no bypass). The new value is visible the next cycle.
  - Aliasing: a different tag at the same index is a miss. A taken update evicts the old entry.
- Reset (reset=0, asynchronous):
  - all valid=0;
  - all ctr = weakly not-taken (MSB=0, other bits 1; e.g. 2'b01);
  - targets and tags = 0;
  - mispredict_count = 0.
  - Outputs during reset: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
  - Reset asserted mid-update abandons the update; no partial write survives.
- X-safety: inputs are ignored while upd_valid=0 and flush=0.

Decomposition:
- Shared package core_pkg:
  - XLEN=64;
  - PC_INC=4;
  - the counter encodings CTR_WEAK_TAKEN and CTR_WEAK_NOT_TAKEN as functions of CTR_W;
  - a function computing IDX_W via clog2.
- One sub-module, sat_counter: parametrised width; inc/dec enable; saturating; CTR_W bits. It is instantiated per entry, and PERF_W-wide as an increment-only counter for mispredict_count.

Test Plan:
- Reset, then lookup_pc=0x1000 -> pred_hit=0, pred_taken=0, pred_target=0x1004; mispredict_count=0.
- Update pc=0x1000, taken, target=0x2000, mispredict=1; then lookup 0x1000 -> hit=1, taken=1, target=0x2000, mispredict_count=1.
- Two not-taken updates of 0x1000 from weakly taken:
  - after the first -> pred_taken=0, ctr=01;
  - after the second -> ctr=00;
  - a third not-taken keeps ctr=00;
  - then two taken updates -> pred_taken=1.
- Aliasing with ENTRIES=16:
  - allocate 0x1000;
  - taken update of 0x1040 (same index, different tag) -> lookup 0x1000 misses with target 0x1004; lookup 0x1040 hits.
- Same-index lookup and allocating update of 0x3000 in the same cycle -> that cycle hit=0; next cycle hit=1.
- Stress and boundaries:
  - flush asserted with a taken update of 0x4000 -> following lookup of 0x4000 misses; mispredict_count unchanged by flush;
  - force the counter near all-ones (PERF_W=4: 15 mispredicts, then 1 more) -> holds at 15;
  - assert reset mid-run -> all entries invalid and count 0 immediately, without waiting for a clock edge.
